spi_regfile_peripheral: RTL
===========================

// Module: spi_regfile_peripheral
// PURPOSE
//   Parametrised SPI (mode 0) peripheral: next generation of the PWM-config SPI slave.
//   Maps serial frames onto NUM_REGS x DATA_W config registers with optional read-back on CIPO.
//   Sits between the chip pins and the PWM/output-enable logic; all state lives in the clk domain.
//   Adds bit-count framing checks, address-range checks and write strobes.
// PARAMETERS
//   NUM_REGS     8   number of config registers (1..2**ADDR_W), addresses 0..NUM_REGS-1
//   ADDR_W       7   address field width
//   DATA_W       8   register/data field width
//   SYNC_STAGES  2   synchroniser flops on nCS/SCLK/COPI (>=2)
// PORTS
//   clk        in   1                  system clock; must be >= 8x SCLK frequency
//   rst        in   1                  synchronous, active-high reset
//   nCS        in   1                  async chip select, active low
//   SCLK       in   1                  async serial clock, idle low
//   COPI       in   1                  async serial data in
//   CIPO       out  1                  serial data out (read-back)
//   CIPO_oe    out  1                  CIPO output enable; 1 only while nCS (synced) low
//   reg_out    out  NUM_REGS*DATA_W    register file, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe  out  NUM_REGS           1-cycle pulse on reg k when reg k is written
//   frame_err  out  1                  1-cycle pulse: frame discarded (bad count / bad addr)
// BEHAVIOUR
//   - Frame: FRAME_W = 1+ADDR_W+DATA_W bits, MSB first: [RW(1=write,0=read)][ADDR][DATA].
//   - All three inputs pass through SYNC_STAGES flops; edges detected on the last two stages.
//     COPI sampled from its synced copy on detected SCLK rise (same delay as SCLK).
//   - FSM: IDLE -> (nCS fall) SHIFT -> (nCS rise) COMMIT -> IDLE. COMMIT lasts exactly 1 cycle.
//     SCLK edges while in IDLE are ignored. nCS fall in SHIFT/COMMIT is not possible without
//     a rise; a rise in IDLE is ignored.
//   - SHIFT: bit counter (clog2(FRAME_W+1)+1 bits) saturates at FRAME_W+1; shift register
//     stops capturing after FRAME_W bits.
//   - COMMIT, write: count==FRAME_W and ADDR<NUM_REGS -> reg[ADDR]<=DATA, wr_strobe[ADDR]=1.
//     Write visible on reg_out SYNC_STAGES+1 clk after the nCS rise reaches the pin.
//   - COMMIT, any frame with count!=FRAME_W (short or long) or ADDR>=NUM_REGS: no register
//     change, frame_err=1 for that cycle. count==0 (nCS toggle, no clocks) -> silent, no err.
//   - Reads never modify registers; a full-length read frame is not an error.
//   - Reset: reg_out=0, wr_strobe=0, frame_err=0, CIPO=0, CIPO_oe=0, FSM=IDLE, sync flops=0.
//     Reset mid-frame abandons the frame; the next frame needs a fresh nCS fall.
//   - wr_strobe and frame_err never assert in the same cycle.
// CONFIGURATION
//   SPI_READBACK_EN defined:
//     - after the last ADDR bit is captured with RW=0, load tx shifter with reg[ADDR]
//       (0 if ADDR>=NUM_REGS); drive MSB on CIPO at the next detected SCLK fall, then
//       one bit per fall; DATA bits on COPI during a read are don't-care.
//     - CIPO=0 outside the data phase; CIPO_oe follows synced nCS low.
//   SPI_READBACK_EN undefined:
//     - no tx shifter; CIPO and CIPO_oe tied 0; RW=0 frames are received and dropped
//       (no err for correct length).
// TESTING
//   1. Write 0x81_A5 (RW=1, addr 1, data A5) -> reg 1 = 0xA5, wr_strobe[1] pulses once, others 0.
//   2. 15-bit frame then 17-bit frame to addr 2 -> reg 2 unchanged, frame_err pulses twice.
//   3. Write to addr 0x7F with NUM_REGS=8 -> no reg change, frame_err=1, wr_strobe=0.
//   4. SPI_READBACK_EN: write 0x3C to addr 4, read addr 4 -> CIPO shifts 0,0,1,1,1,1,0,0.
//   5. Assert rst after 9 SCLK rises of a write -> all regs 0; following full write commits normally.
//   6. SCLK toggling with nCS high, then nCS pulse with 0 clocks -> no writes, no frame_err.

Source files
------------

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral mapping [RW][ADDR][DATA] frames onto a config register file.
// Optional CIPO read-back is built when SPI_READBACK_EN is defined.
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 8,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1) + 1;
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int AW1     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] ADDR_CNT  = CNT_W'(ADDR_W);
    localparam logic [AW1-1:0]   NREGS_A   = AW1'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ncs_sync, sclk_sync, copi_sync;
    logic [CNT_W-1:0]       cnt;
    logic [FRAME_W-1:0]     sr, sr_next;
    logic [DATA_W-1:0]      regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_sync  <= '0;
            sclk_sync <= '0;
            copi_sync <= '0;
        end else begin
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
        end
    end

    logic ncs_fall, ncs_rise, sclk_rise, copi_s;
    assign ncs_fall  = ~ncs_sync[SYNC_STAGES-2] &  ncs_sync[SYNC_STAGES-1];
    assign ncs_rise  =  ncs_sync[SYNC_STAGES-2] & ~ncs_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
    assign copi_s    =  copi_sync[SYNC_STAGES-1];
    assign sr_next   = {sr[FRAME_W-2:0], copi_s};

    logic              frame_rw, addr_ok;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    assign frame_rw   = sr[FRAME_W-1];
    assign frame_addr = sr[FRAME_W-2 -: ADDR_W];
    assign frame_data = sr[DATA_W-1:0];
    assign addr_ok    = {1'b0, frame_addr} < NREGS_A;

`ifdef SPI_READBACK_EN
    localparam int TX_W = $clog2(DATA_W + 1);
    logic              sclk_fall, rd_ok;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data, tx_sr;
    logic [TX_W-1:0]   tx_left;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
    // Address is taken from the shift value being captured this cycle.
    assign rd_addr   = sr_next[ADDR_W-1:0];
    assign rd_ok     = {1'b0, rd_addr} < NREGS_A;
    assign rd_data   = rd_ok ? regs[rd_addr[IDX_W-1:0]] : '0;
`else
    assign CIPO    = 1'b0;
    assign CIPO_oe = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
            for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
`ifdef SPI_READBACK_EN
            tx_sr   <= '0;
            tx_left <= '0;
            CIPO    <= 1'b0;
            CIPO_oe <= 1'b0;
`endif
        end else begin
            wr_strobe <= '0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        sr    <= '0;
`ifdef SPI_READBACK_EN
                        tx_left <= '0;
                        CIPO    <= 1'b0;
                        CIPO_oe <= 1'b1;
`endif
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        if (cnt < FRAME_CNT) sr <= sr_next;
                        if (cnt <= FRAME_CNT) cnt <= cnt + 1'b1;
`ifdef SPI_READBACK_EN
                        if (cnt == ADDR_CNT && !sr_next[ADDR_W]) begin
                            tx_sr   <= rd_data;
                            tx_left <= TX_W'(DATA_W);
                        end
`endif
                    end
`ifdef SPI_READBACK_EN
                    if (sclk_fall) begin
                        if (tx_left != '0) begin
                            CIPO    <= tx_sr[DATA_W-1];
                            tx_sr   <= tx_sr << 1;
                            tx_left <= tx_left - 1'b1;
                        end else begin
                            CIPO <= 1'b0;
                        end
                    end
`endif
                    if (ncs_rise) begin
                        state <= COMMIT;
`ifdef SPI_READBACK_EN
                        CIPO    <= 1'b0;
                        CIPO_oe <= 1'b0;
                        tx_left <= '0;
`endif
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (cnt != '0) begin
                        if (cnt != FRAME_CNT || !addr_ok) begin
                            frame_err <= 1'b1;
                        end else if (frame_rw) begin
                            regs[frame_addr[IDX_W-1:0]]      <= frame_data;
                            wr_strobe[frame_addr[IDX_W-1:0]] <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++)
            reg_out[k*DATA_W +: DATA_W] = regs[k];
    end

endmodule
